// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter_pkg
// Brief    : Shared register-file widths, write-entry type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

    localparam int c_reg_w    = 3;
    localparam int c_data_w   = 16;
    localparam int c_num_regs = 1 << c_reg_w;

    typedef struct packed {
        logic [c_reg_w-1:0]  dest;
        logic [c_data_w-1:0] data;
    } wr_entry_t;

    function automatic logic [c_num_regs-1:0] dest_onehot(input logic [c_reg_w-1:0] dest);
        dest_onehot       = '0;
        dest_onehot[dest] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter_if
// Brief    : WB / aux / register-file / hazard-unit signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    import rf_write_arbiter_pkg::*;

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    logic                  wb_write_en;
    logic [c_reg_w-1:0]    wb_write_dest;
    logic [c_data_w-1:0]   wb_write_data;
    logic                  aux_valid;
    logic                  aux_ready;
    logic [c_reg_w-1:0]    aux_dest;
    logic [c_data_w-1:0]   aux_data;
    logic                  reg_write_en;
    logic [c_reg_w-1:0]    reg_write_dest;
    logic [c_data_w-1:0]   reg_write_data;
    logic [c_num_regs-1:0] pending_dest_mask;
    logic                  bubble_req;
    logic [c_cnt_w-1:0]    fifo_count;

    modport slave (
        input  wb_write_en, wb_write_dest, wb_write_data,
        input  aux_valid, aux_dest, aux_data,
        output aux_ready,
        output reg_write_en, reg_write_dest, reg_write_data,
        output pending_dest_mask, bubble_req, fifo_count
    );

    modport master (
        output wb_write_en, wb_write_dest, wb_write_data,
        output aux_valid, aux_dest, aux_data,
        input  aux_ready,
        input  reg_write_en, reg_write_dest, reg_write_data,
        input  pending_dest_mask, bubble_req, fifo_count
    );

endinterface
`default_nettype wire

// File: rtl/rf_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_fifo
// Brief    : Synchronous aux write buffer exposing head, count and per-entry
//            valid/dest so the parent can build the pending-destination mask.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wr_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           push,
    input  wire wr_entry_t                      push_entry,
    input  wire logic                           pop,
    output wr_entry_t                           head,
    output logic [$clog2(DEPTH):0]              count,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][c_reg_w-1:0]       entry_dest
);

    localparam int c_ptr_w = $clog2(DEPTH);

    wr_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head        = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign entry_valid = r_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_dest
        assign entry_dest[i] = r_mem[i].dest;
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Shares the register-file write port between WB (fixed priority,
//            combinational) and a FIFO-buffered aux requester with bounded wait.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rf_write_arbiter_if.slave  bus
);

    localparam int         c_cnt_w        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    wr_entry_t                          w_head;
    logic [c_cnt_w-1:0]                 w_count;
    logic [FIFO_DEPTH-1:0]              w_entry_valid;
    logic [FIFO_DEPTH-1:0][c_reg_w-1:0] w_entry_dest;
    logic                               w_empty;
    logic                               w_full;
    logic                               w_aux_ready;
    logic                               w_push;
    logic                               w_pop;
    logic [c_num_regs-1:0]              w_mask;
    logic                               w_wr_en;
    logic [c_reg_w-1:0]                 w_wr_dest;
    logic [c_data_w-1:0]                w_wr_data;
    logic [3:0]                         r_starve_cnt;

    // aux_ready depends only on registered occupancy, never on this cycle's grant.
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == c_cnt_w'(FIFO_DEPTH));
    assign w_aux_ready = !rst && !w_full;
    assign w_push      = bus.aux_valid && w_aux_ready;
    assign w_pop       = !rst && !bus.wb_write_en && !w_empty;

    rf_wr_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .push_entry  ({bus.aux_dest, bus.aux_data}),
        .pop         (w_pop),
        .head        (w_head),
        .count       (w_count),
        .entry_valid (w_entry_valid),
        .entry_dest  (w_entry_dest)
    );

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_dest = '0;
        w_wr_data = '0;
        if (!rst) begin
            if (bus.wb_write_en) begin
                w_wr_en   = 1'b1;
                w_wr_dest = bus.wb_write_dest;
                w_wr_data = bus.wb_write_data;
            end else if (!w_empty) begin
                w_wr_en   = 1'b1;
                w_wr_dest = w_head.dest;
                w_wr_data = w_head.data;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_mask = w_mask | dest_onehot(w_entry_dest[i]);
            end
        end
    end

    // Counts edges where a waiting head lost to WB; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_limit) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign bus.aux_ready         = w_aux_ready;
    assign bus.reg_write_en      = w_wr_en;
    assign bus.reg_write_dest    = w_wr_dest;
    assign bus.reg_write_data    = w_wr_data;
    assign bus.pending_dest_mask = rst ? '0 : w_mask;
    assign bus.bubble_req        = !rst && (r_starve_cnt == c_starve_limit);
    assign bus.fifo_count        = rst ? '0 : w_count;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed bench for rf_write_arbiter with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    rf_write_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int        n_vec = 0;
    int        n_err = 0;
    wr_entry_t exp_q[$];
    wr_entry_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive after the edge, then return at the following negedge.
    task automatic cyc(input logic r,
                       input logic we, input logic [2:0] wd, input logic [15:0] wx,
                       input logic av, input logic [2:0] ad, input logic [15:0] ax);
        @(posedge clk);
        #1;
        rst               = r;
        bus.wb_write_en   = we;
        bus.wb_write_dest = wd;
        bus.wb_write_data = wx;
        bus.aux_valid     = av;
        bus.aux_dest      = ad;
        bus.aux_data      = ax;
        if (we && !r) exp_q.push_back('{dest: wd, data: wx});
        @(negedge clk);
    endtask

    task automatic expect_aux(input logic [2:0] d, input logic [15:0] x);
        exp_q.push_back('{dest: d, data: x});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    always @(negedge clk) begin
        if (bus.reg_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got dest %0d data 0x%0h, required none (t=%0t)",
                         bus.reg_write_dest, bus.reg_write_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rf_write", 32'({bus.reg_write_dest, bus.reg_write_data}), 32'(mon_e));
            end
        end
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        bus.wb_write_en = 1'b0; bus.wb_write_dest = '0; bus.wb_write_data = '0;
        bus.aux_valid   = 1'b0; bus.aux_dest      = '0; bus.aux_data      = '0;

        // Reset with both requesters active
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 3'd1, 16'h0001, 1'b1, 3'd7, 16'hFFFF);
            chk("rst_aux_ready", 32'(bus.aux_ready), 0);
            chk("rst_wr_en",     32'(bus.reg_write_en), 0);
            chk("rst_wr_dest",   32'(bus.reg_write_dest), 0);
            chk("rst_wr_data",   32'(bus.reg_write_data), 0);
            chk("rst_mask",      32'(bus.pending_dest_mask), 0);
            chk("rst_bubble",    32'(bus.bubble_req), 0);
            chk("rst_count",     32'(bus.fifo_count), 0);
        end
        idle();
        chk("post_rst_aux_ready", 32'(bus.aux_ready), 1);
        chk("post_rst_count",     32'(bus.fifo_count), 0);

        // Idle drain
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
        chk("drain_mask_before", 32'(bus.pending_dest_mask), 0);
        expect_aux(3'd3, 16'h1234);
        idle();
        chk("drain_wr_en",  32'(bus.reg_write_en), 1);
        chk("drain_mask",   32'(bus.pending_dest_mask), 32'h08);
        chk("drain_count",  32'(bus.fifo_count), 1);
        idle();
        chk("drain_done_en",    32'(bus.reg_write_en), 0);
        chk("drain_done_mask",  32'(bus.pending_dest_mask), 0);
        chk("drain_done_count", 32'(bus.fifo_count), 0);

        // WB priority over a buffered head
        cyc(1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd5, 16'hBEEF);
        cyc(1'b0, 1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 16'h0);
        chk("prio_mask",  32'(bus.pending_dest_mask), 32'h20);
        chk("prio_count", 32'(bus.fifo_count), 1);
        expect_aux(3'd5, 16'hBEEF);
        idle();
        chk("prio_head_en", 32'(bus.reg_write_en), 1);
        idle();
        chk("prio_done_count", 32'(bus.fifo_count), 0);

        // Full / backpressure with WB busy
        cyc(1'b0, 1'b1, 3'd6, 16'h1000, 1'b1, 3'd1, 16'hA001);
        chk("bp_ready0", 32'(bus.aux_ready), 1);
        cyc(1'b0, 1'b1, 3'd6, 16'h1001, 1'b1, 3'd2, 16'hA002);
        chk("bp_ready1", 32'(bus.aux_ready), 1);
        chk("bp_count1", 32'(bus.fifo_count), 1);
        cyc(1'b0, 1'b1, 3'd6, 16'h1002, 1'b1, 3'd3, 16'hA003);
        chk("bp_full_ready", 32'(bus.aux_ready), 0);
        chk("bp_full_count", 32'(bus.fifo_count), 2);
        chk("bp_full_mask",  32'(bus.pending_dest_mask), 32'h06);
        expect_aux(3'd1, 16'hA001);
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'hA003);
        chk("bp_pop_ready", 32'(bus.aux_ready), 0);
        chk("bp_pop_count", 32'(bus.fifo_count), 2);
        expect_aux(3'd2, 16'hA002);
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'hA003);
        chk("bp_free_ready", 32'(bus.aux_ready), 1);
        chk("bp_free_count", 32'(bus.fifo_count), 1);
        chk("bp_free_mask",  32'(bus.pending_dest_mask), 32'h04);
        expect_aux(3'd3, 16'hA003);
        idle();
        chk("bp_last_count", 32'(bus.fifo_count), 1);
        chk("bp_last_mask",  32'(bus.pending_dest_mask), 32'h08);
        idle();
        chk("bp_done_count", 32'(bus.fifo_count), 0);

        // Starvation and bubble request
        cyc(1'b0, 1'b1, 3'd7, 16'h2000, 1'b1, 3'd4, 16'hC0DE);
        chk("starve_bubble0", 32'(bus.bubble_req), 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b1, 3'd7, 16'(16'h2000 + k), 1'b0, 3'd0, 16'h0);
            chk("starve_bubble_low", 32'(bus.bubble_req), 0);
        end
        cyc(1'b0, 1'b1, 3'd7, 16'h2005, 1'b0, 3'd0, 16'h0);
        chk("starve_bubble_high", 32'(bus.bubble_req), 1);
        expect_aux(3'd4, 16'hC0DE);
        idle();
        chk("starve_bubble_hold", 32'(bus.bubble_req), 1);
        chk("starve_head_en",     32'(bus.reg_write_en), 1);
        idle();
        chk("starve_bubble_fall", 32'(bus.bubble_req), 0);
        chk("starve_count",       32'(bus.fifo_count), 0);

        // Reset asserted mid-drain
        cyc(1'b0, 1'b1, 3'd2, 16'h3000, 1'b1, 3'd1, 16'hD001);
        cyc(1'b0, 1'b1, 3'd2, 16'h3001, 1'b1, 3'd6, 16'hD006);
        chk("mid_count1", 32'(bus.fifo_count), 1);
        cyc(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        chk("mid_rst_count", 32'(bus.fifo_count), 0);
        chk("mid_rst_mask",  32'(bus.pending_dest_mask), 0);
        chk("mid_rst_en",    32'(bus.reg_write_en), 0);
        chk("mid_rst_ready", 32'(bus.aux_ready), 0);
        idle();
        chk("mid_after_count", 32'(bus.fifo_count), 0);
        chk("mid_after_mask",  32'(bus.pending_dest_mask), 0);
        chk("mid_after_en",    32'(bus.reg_write_en), 0);
        chk("mid_after_ready", 32'(bus.aux_ready), 1);
        idle();
        chk("mid_after2_en", 32'(bus.reg_write_en), 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the WB stage and an auxiliary multi-cycle requester (multiply/divide unit or debug writer). WB writes have fixed priority and pass through combinationally. Aux writes are buffered in a small FIFO and drained into idle WB cycles. Starvation is bounded by requesting a pipeline bubble from the hazard detection unit. Sits between WB stage, aux unit, hazard unit and register file.

## Interface

Parameters:
- FIFO_DEPTH, 2: aux write buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 4: consecutive lost cycles before a bubble is requested (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wb_write_en  in  1  WB stage write request
- wb_write_dest  in  3  WB destination register
- wb_write_data  in  16  WB write data
- aux_valid  in  1  aux write offered
- aux_ready  out  1  FIFO can accept aux write
- aux_dest  in  3  aux destination register
- aux_data  in  16  aux write data
- reg_write_en  out  1  to register file
- reg_write_dest  out  3  to register file
- reg_write_data  out  16  to register file
- pending_dest_mask  out  8  bit r set while any FIFO entry targets register r
- bubble_req  out  1  to hazard unit: inject a WB bubble
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy

## Operation

- Accept: push when aux_valid && aux_ready at the clock edge. aux_ready = !rst && (fifo_count != FIFO_DEPTH). A same-cycle pop does not free space for that cycle's push; there is no combinational path from grant to aux_ready.
- Every aux write goes through the FIFO. There is no bypass.
- Grant, combinational:
  - If wb_write_en, the WB stage owns the port.
  - Else if the FIFO is non-empty, the head owns the port and pops at the edge.
  - Else reg_write_en = 0.
- Output data/dest mux follows the grant. When no one writes, dest and data are 0.
- Starvation counter cnt (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each edge where the FIFO is non-empty and the head is not granted.
  - Clears on a head pop or when the FIFO is empty.
- bubble_req = (cnt == STARVE_LIMIT), a decode of a registered value. It stays high until the head is granted.
- Hazard unit contract for bubble_req: on seeing it, the hazard unit forces wb_write_en = 0 in a later cycle, within 2 cycles. The head then wins.
- pending_dest_mask is the OR of one-hot(dest) over valid FIFO entries. It is updated after each push/pop edge.
- Hazard unit contract for pending_dest_mask: it stalls any instruction that reads or writes a masked register. This guarantees no WAW/RAW between WB and the FIFO. The arbiter does no ordering checks.
- Writes to R0 are arbitrated normally; the register file ignores them.
- rst high:
  - FIFO empties, cnt = 0.
  - Outputs: aux_ready 0, reg_write_en 0, reg_write_dest 0, reg_write_data 0, pending_dest_mask 0, bubble_req 0, fifo_count 0.
  - A push or WB request present during rst is discarded.
  - Reset asserted mid-drain drops all buffered entries.

## Timing

- WB path latency: 0 cycles, combinational input to output.
- Aux path latency: accepted at edge N, earliest register-file write in cycle N+1, committing at edge N+2.
- FIFO full: aux_ready low; aux holds valid/dest/data stable until accepted.
- Push and pop at the same edge: count unchanged, mask updated for both.
- A write that is pushed while the FIFO is empty appears in pending_dest_mask from cycle N+1.
- Starvation: with WB writing every cycle and the head waiting, bubble_req goes high in the cycle after the STARVE_LIMIT-th lost edge. It falls the cycle after the pop edge.
- Worst-case aux wait: STARVE_LIMIT + 2 (bubble latency) + 1 cycles per entry.

## Structure

- Register-width constant (3) and data-width constant (16) belong in the shared mips_16 definitions file. Reuse those; do not add local literals.
- Sub-module rf_wr_fifo:
  - Synchronous FIFO, depth FIFO_DEPTH, 19-bit entries {dest, data}.
  - Exposes head, count and per-entry valid/dest for mask generation.
  - Arbitration, counter and mask OR stay in rf_write_arbiter.

## Test plan

- Reset: hold rst 3 cycles with aux_valid=1, wb_write_en=1 → all outputs 0, aux_ready 0. First cycle after reset: aux_ready=1, fifo_count=0.
- Idle drain: push {R3,0x1234} at edge N with WB idle → cycle N+1: reg_write_en=1, dest=3, data=0x1234. Mask bit 3 set in cycle N+1 and clear in N+2.
- WB priority: FIFO holds {R5,0xBEEF} while WB writes {R2,0x00AA} → WB written first. FIFO write follows in the first cycle with wb_write_en=0.
- Full/backpressure: push 3 entries back-to-back with WB busy, DEPTH=2 → aux_ready low after 2 pushes, fifo_count=2. Third entry is accepted on the first edge after a pop frees space.
- Starvation: WB writes every cycle, one entry buffered, LIMIT=4 → bubble_req high after the 4th lost edge. Bench drops wb_write_en next cycle → head written, bubble_req low the following cycle.
- Mid-drain reset: 2 entries buffered, rst pulsed 1 cycle → no further aux writes, mask 0, fifo_count 0.
